// File: rtl/fp_from_int_issue_if.sv
// Issue/retire handshake bundle for fp_from_int_issue.
//   in_*  : request channel (valid/ready, 32-bit operand, signedness, tag)
//   out_* : result channel (valid/ready, FP32 result, tag)
// master drives requests and accepts results; slave is the wrapper side.
interface fp_from_int_issue_if #(
    parameter int unsigned TAG_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_data;
    logic                 in_signed;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_data;
    logic [TAG_WIDTH-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/fp_from_int_issue.sv
// Valid/ready wrapper around a fixed-latency, non-stalling unsigned int->FP32 converter.
// Requests are converted to a magnitude for the converter; a metadata pipe carries
// {valid, neg, tag} alongside so the sign can be restored when the converter result
// arrives. Results land in a credit-protected FIFO so output backpressure never drops one.
// Ports:
//   clk, areset : clock, synchronous active-high reset
//   bus         : request/result handshake bundle (slave side)
//   conv_a      : registered magnitude to the converter
//   conv_q      : FP32 result from the converter, LATENCY cycles after conv_a
module fp_from_int_issue #(
    parameter int unsigned LATENCY   = 7,
    parameter int unsigned TAG_WIDTH = 5,
    parameter int unsigned BUF_DEPTH = 10
) (
    input  logic               clk,
    input  logic               areset,
    fp_from_int_issue_if.slave bus,
    output logic [31:0]        conv_a,
    input  logic [31:0]        conv_q
);
    localparam int unsigned CntW   = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PtrW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // One stage more than LATENCY: conv_a is itself a register stage ahead of the converter.
    localparam int unsigned Stages = LATENCY + 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(BUF_DEPTH - 1);
    localparam logic [CntW:0]   DepthC  = (CntW + 1)'(BUF_DEPTH);

    typedef struct packed {
        logic                 valid;
        logic                 neg;
        logic [TAG_WIDTH-1:0] tag;
    } meta_t;

    meta_t                pipe_q [Stages];
    logic [31:0]          fifo_data_q [BUF_DEPTH];
    logic [TAG_WIDTH-1:0] fifo_tag_q [BUF_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, inflight_q;

    logic        acc, ret, deq, acc_neg;
    logic [CntW:0] credits_used;
    meta_t       head;

    assign head         = pipe_q[Stages-1];
    assign acc_neg      = bus.in_signed & bus.in_data[31];
    // Every accepted item owns a FIFO slot from accept until dequeue.
    assign credits_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign bus.in_ready  = ~areset & (credits_used < DepthC);
    assign bus.out_valid = ~areset & (count_q != '0);
    assign bus.out_data  = fifo_data_q[rd_ptr_q];
    assign bus.out_tag   = fifo_tag_q[rd_ptr_q];
    assign acc = bus.in_valid & bus.in_ready;
    assign ret = head.valid;
    assign deq = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (areset) begin
            for (int i = 0; i < int'(Stages); i++) begin
                pipe_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            conv_a     <= '0;
        end else begin
            pipe_q[0] <= {acc, acc & acc_neg, bus.in_tag};
            for (int i = 1; i < int'(Stages); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            // Two's-complement negate; INT_MIN maps onto itself, which is its magnitude.
            if (acc) begin
                conv_a <= acc_neg ? (~bus.in_data + 32'd1) : bus.in_data;
            end
            if (ret) begin
                fifo_data_q[wr_ptr_q] <= {conv_q[31] | head.neg, conv_q[30:0]};
                fifo_tag_q[wr_ptr_q]  <= head.tag;
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q    <= count_q + CntW'(ret) - CntW'(deq);
            inflight_q <= inflight_q + CntW'(acc) - CntW'(ret);
        end
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            assert (count_q <= CntW'(BUF_DEPTH));
            assert (inflight_q <= CntW'(LATENCY + 1));
            assert (!(ret && count_q == CntW'(BUF_DEPTH)));
        end
    end
endmodule

// File: tb/tb_fp_from_int_issue.sv
// Bench for fp_from_int_issue: models the converter as a LATENCY-stage pipe of a
// reference unsigned int->FP32 (round-nearest-even) and checks directed scenarios.
module tb_fp_from_int_issue;
    localparam int unsigned Lat = 7;
    localparam int unsigned Tw  = 5;
    localparam int unsigned Dep = 10;

    logic        clk;
    logic        areset;
    logic [31:0] conv_a;
    logic [31:0] conv_q;
    logic [31:0] conv_pipe [Lat];

    fp_from_int_issue_if #(.TAG_WIDTH(Tw)) bus ();

    fp_from_int_issue #(
        .LATENCY  (Lat),
        .TAG_WIDTH(Tw),
        .BUF_DEPTH(Dep)
    ) dut (
        .clk   (clk),
        .areset(areset),
        .bus   (bus),
        .conv_a(conv_a),
        .conv_q(conv_q)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc[$];
    int got_cyc[$];
    logic [31:0]   got_data[$];
    logic [Tw-1:0] got_tag[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] u2f(input logic [31:0] x);
        int p;
        int e;
        int sh;
        logic [31:0] m;
        logic [31:0] rem;
        logic [31:0] half;
        if (x == 32'd0) return 32'd0;
        p = 31;
        while (!x[p]) p--;
        e = 127 + p;
        if (p <= 23) begin
            m = x << (23 - p);
        end else begin
            sh   = p - 23;
            m    = x >> sh;
            rem  = x & ((32'd1 << sh) - 32'd1);
            half = 32'd1 << (sh - 1);
            if (rem > half || (rem == half && m[0])) m = m + 32'd1;
            if (m[24]) begin
                m = m >> 1;
                e++;
            end
        end
        return {1'b0, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] ref_conv(input logic [31:0] d, input logic s);
        logic neg;
        logic [31:0] f;
        neg = s & d[31];
        f = u2f(neg ? (~d + 32'd1) : d);
        f[31] = f[31] | neg;
        return f;
    endfunction

    // Converter model: conv_a in cycle c shows up on conv_q in cycle c+Lat.
    always @(posedge clk) begin
        conv_pipe[0] <= u2f(conv_a);
        for (int i = 1; i < int'(Lat); i++) conv_pipe[i] <= conv_pipe[i-1];
    end
    assign conv_q = conv_pipe[Lat-1];

    // Record accepts and dequeues with the cycle they happen in.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!areset && bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_tag.push_back(bus.out_tag);
            got_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (got_data.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (got_data.size() >= n);
    endtask

    task automatic idle_drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) step();
        acc_cyc.delete();
        got_cyc.delete();
        got_data.delete();
        got_tag.delete();
    endtask

    task automatic test_reset();
        areset        = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'd7;
        bus.in_signed = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        bus.in_valid = 1'b0;
        areset       = 1'b0;
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (conv_a !== 32'd0) begin
            errors++;
            $display("FAIL post_reset_conv_a: got %h want 00000000", conv_a);
        end
    endtask

    task automatic test_single();
        bit ok;
        idle_drain();
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0001;
        bus.in_signed = 1'b0;
        bus.in_tag    = 5'd3;
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (conv_a !== 32'h0000_0001) begin
            errors++;
            $display("FAIL single_conv_a: got %h want 00000001", conv_a);
        end
        wait_n(1, 30, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout: got %0d results want 1", got_data.size());
        end else begin
            checks++;
            if (got_data[0] !== 32'h3F80_0000) begin
                errors++;
                $display("FAIL single_data: got %h want 3f800000", got_data[0]);
            end
            checks++;
            if (got_tag[0] !== 5'd3) begin
                errors++;
                $display("FAIL single_tag: got %0d want 3", got_tag[0]);
            end
            checks++;
            if (got_cyc[0] - acc_cyc[0] !== 9) begin
                errors++;
                $display("FAIL single_latency: got %0d want 9", got_cyc[0] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_signs();
        logic [31:0] din  [4];
        logic        sgn  [4];
        logic [31:0] mag  [4];
        logic [31:0] want [4];
        bit ok;
        din[0] = 32'hFFFF_FFFF; sgn[0] = 1'b1; mag[0] = 32'h0000_0001; want[0] = 32'hBF80_0000;
        din[1] = 32'h8000_0000; sgn[1] = 1'b1; mag[1] = 32'h8000_0000; want[1] = 32'hCF00_0000;
        din[2] = 32'h8000_0000; sgn[2] = 1'b0; mag[2] = 32'h8000_0000; want[2] = 32'h4F00_0000;
        din[3] = 32'h0000_0000; sgn[3] = 1'b1; mag[3] = 32'h0000_0000; want[3] = 32'h0000_0000;
        idle_drain();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = din[i];
            bus.in_signed = sgn[i];
            bus.in_tag    = 5'(10 + i);
            step();
            checks++;
            if (conv_a !== mag[i]) begin
                errors++;
                $display("FAIL sign_conv_a[%0d]: got %h want %h", i, conv_a, mag[i]);
            end
        end
        bus.in_valid = 1'b0;
        wait_n(4, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sign_timeout: got %0d results want 4", got_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_data[i] !== want[i] || got_tag[i] !== 5'(10 + i)) begin
                    errors++;
                    $display("FAIL sign_result[%0d]: got %h/%0d want %h/%0d",
                             i, got_data[i], got_tag[i], want[i], 10 + i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]   exp_d[$];
        logic [Tw-1:0] exp_t[$];
        logic [31:0]   d;
        logic          s;
        int drops;
        bit ok;
        idle_drain();
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            d = $urandom;
            s = 1'($urandom_range(0, 1));
            bus.in_valid  = 1'b1;
            bus.in_data   = d;
            bus.in_signed = s;
            bus.in_tag    = 5'(i);
            if (bus.in_ready !== 1'b1) drops++;
            exp_d.push_back(ref_conv(d, s));
            exp_t.push_back(5'(i));
            step();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (drops != 0) begin
            errors++;
            $display("FAIL stream_in_ready: got %0d drop cycles want 0", drops);
        end
        wait_n(100, 200, ok);
        checks++;
        if (!ok || got_data.size() != 100) begin
            errors++;
            $display("FAIL stream_count: got %0d results want 100", got_data.size());
        end else begin
            for (int i = 0; i < 100; i++) begin
                checks++;
                if (got_data[i] !== exp_d[i] || got_tag[i] !== exp_t[i]) begin
                    errors++;
                    $display("FAIL stream_result[%0d]: got %h/%0d want %h/%0d",
                             i, got_data[i], got_tag[i], exp_d[i], exp_t[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (got_cyc[i] - got_cyc[i-1] != 1) begin
                        errors++;
                        $display("FAIL stream_gap[%0d]: got %0d cycles want 1",
                                 i, got_cyc[i] - got_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int nacc;
        bit ok;
        idle_drain();
        bus.out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 30; c++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'(100 + nacc);
            bus.in_signed = 1'b0;
            bus.in_tag    = 5'(nacc);
            if (bus.in_ready === 1'b1) nacc++;
            step();
        end
        checks++;
        if (nacc != 10) begin
            errors++;
            $display("FAIL bp_accepted: got %0d want 10", nacc);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full_in_ready: got %b want 0", bus.in_ready);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_deq_cycle_in_ready: got %b want 0", bus.in_ready);
        end
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_reassert: got %b want 1", bus.in_ready);
        end
        wait_n(10, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_timeout: got %0d results want 10", got_data.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (got_data[i] !== u2f(32'(100 + i)) || got_tag[i] !== 5'(i)) begin
                    errors++;
                    $display("FAIL bp_result[%0d]: got %h/%0d want %h/%0d",
                             i, got_data[i], got_tag[i], u2f(32'(100 + i)), i);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        bit ok;
        idle_drain();
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 32'(5 + i);
            bus.in_signed = 1'b0;
            bus.in_tag    = 5'(20 + i);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        areset = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_in_ready: got %b want 0", bus.in_ready);
        end
        areset = 1'b0;
        got_data.delete();
        got_tag.delete();
        got_cyc.delete();
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_post_in_ready: got %b want 1", bus.in_ready);
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_0002;
        bus.in_signed = 1'b0;
        bus.in_tag    = 5'd9;
        step();
        bus.in_valid = 1'b0;
        wait_n(1, 30, ok);
        repeat (15) step();
        checks++;
        if (got_data.size() != 1) begin
            errors++;
            $display("FAIL mid_count: got %0d results want 1", got_data.size());
        end else begin
            checks++;
            if (got_data[0] !== 32'h4000_0000 || got_tag[0] !== 5'd9) begin
                errors++;
                $display("FAIL mid_result: got %h/%0d want 40000000/9", got_data[0], got_tag[0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        idle_drain();
        bus.out_ready = 1'b0;
        // Items 0..8 accepted in cycles 0..8; item 8 retires in cycle 16.
        for (int c = 0; c < 17; c++) begin
            bus.in_valid  = 1'b0;
            bus.in_signed = 1'b0;
            if (c < 9) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 32'(200 + c);
                bus.in_tag   = 5'(c);
            end else if (c == 16) begin
                bus.in_valid  = 1'b1;
                bus.in_data   = 32'd209;
                bus.in_tag    = 5'd9;
                bus.out_ready = 1'b1;
                checks++;
                if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_pre: got ready=%b valid=%b want 1/1",
                             bus.in_ready, bus.out_valid);
                end
            end
            step();
        end
        checks++;
        if (dut.count_q !== 4'd8) begin
            errors++;
            $display("FAIL simul_count: got %0d want 8", dut.count_q);
        end
        checks++;
        if (dut.inflight_q !== 4'd1) begin
            errors++;
            $display("FAIL simul_inflight: got %0d want 1", dut.inflight_q);
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'd210;
        bus.in_tag    = 5'd10;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL simul_one_credit: got %b want 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_no_credit: got %b want 0", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        wait_n(11, 60, ok);
        repeat (5) step();
        checks++;
        if (got_data.size() != 11) begin
            errors++;
            $display("FAIL simul_total: got %0d results want 11", got_data.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (got_data[i] !== u2f(32'(200 + i)) || got_tag[i] !== 5'(i)) begin
                    errors++;
                    $display("FAIL simul_result[%0d]: got %h/%0d want %h/%0d",
                             i, got_data[i], got_tag[i], u2f(32'(200 + i)), i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_signs();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
